// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default line timing
// and the frame parity helper, common to the transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int unsigned PS2_INHIBIT_CYCLES = 5000;
  localparam int unsigned PS2_RTS_CYCLES     = 250;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 1000000;

  // Odd parity: the nine bits (data + parity) always hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-stage synchronizer for the PS/2 clock and data lines, plus a one-cycle
// falling-edge pulse on the synchronized clock.
module ps2_line_sync (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle PS/2 lines float high, so every stage resets to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// data/parity/stop shifting, ack sampling and a watchdog abort.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned RTS_CYCLES     = PS2_RTS_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  ps2_state_t  state;
  logic [7:0]  data_q;
  logic [31:0] cnt;
  logic [31:0] wdog;
  logic [3:0]  bit_cnt;
  logic        clk_s;
  logic        data_s;
  logic        fall;
  logic        watched;

  ps2_line_sync u_sync (
    .clk         (clk),
    .clr         (clr),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (clk_s),
    .data_s      (data_s),
    .fall        (fall)
  );

  assign watched = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      data_q      <= '0;
      cnt         <= '0;
      wdog        <= '0;
      bit_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      // The watchdog outranks any frame progress made in its final cycle.
      if (watched && wdog == TIMEOUT_CYCLES - 1) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        busy        <= 1'b0;
        timeout     <= 1'b1;
        state       <= IDLE;
      end else begin
        if (watched) wdog <= wdog + 32'd1;
        case (state)
          IDLE: begin
            if (start) begin
              data_q     <= tx_data;
              ack_err    <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt == INHIBIT_CYCLES - 1) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= RTS;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          RTS: begin
            if (cnt == RTS_CYCLES - 1) begin
              cnt        <= '0;
              wdog       <= '0;
              bit_cnt    <= '0;
              ps2_clk_oe <= 1'b0;
              state      <= SEND;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          SEND: begin
            if (fall) begin
              if (bit_cnt < 4'd8) begin
                ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                bit_cnt     <= bit_cnt + 4'd1;
              end else if (bit_cnt == 4'd8) begin
                ps2_data_oe <= ~odd_parity(data_q);
                bit_cnt     <= bit_cnt + 4'd1;
              end else begin
                ps2_data_oe <= 1'b0;
                state       <= ACK;
              end
            end
          end
          ACK: begin
            if (fall) begin
              ack_err <= data_s;
              state   <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
